// File: rtl/eth_gmii_rx.sv
// ============================================================================
// Module   : eth_gmii_rx (with helper crc32_d8)
// Purpose  : GMII receive front end for one switch port. Strips the
//            preamble and SFD, writes payload bytes (FCS removed) to the
//            port data FIFO, checks the FCS, and writes one 72-bit
//            descriptor per frame to the cmd FIFO.
//            Descriptor: [13:0] length, [52] crc_err,
//            [53] frame_err | runt. All other bits are 0.
// Ports    : clk, reset (async, active-high)
//            sgmii_clk_en                 byte-slot qualifier
//            gmii_rxd/gmii_rx_dv/gmii_rx_er GMII receive inputs
//            data_fifo_wr/data_fifo_data_in/data_fifo_afull  data FIFO side
//            cmd_fifo_wr/cmd_fifo_data_in/cmd_fifo_full      cmd FIFO side
//            drop_cnt                     saturating count of frames
//                                         dropped at SFD
//            good_frame_cnt/crc_err_cnt   only with ETH_GMII_RX_STATS_EN
// Options  : `define ETH_GMII_RX_STATS_EN adds the two 32-bit frame
//            statistics counters and their output ports.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

// ----------------------------------------------------------------------------
// crc32_d8: byte-wide Ethernet CRC-32 (reflected, poly 0xEDB88320).
// new_crc is the FCS of the running value including this cycle's byte when
// en=1, arranged so that new_crc[31:24] is the first byte on the wire.
// ----------------------------------------------------------------------------
module crc32_d8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        init,
    input  logic        en,
    input  logic [7:0]  data,
    output logic [31:0] new_crc
);
    logic [31:0] crc_q;
    logic [31:0] crc_d;
    logic [31:0] crc_upd;
    logic [31:0] crc_inv;

    function automatic logic [31:0] crc_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
        logic [31:0] r;
        logic        fb;
        r = c;
        for (int i = 0; i < 8; i++) begin
            fb = r[0] ^ d[i];
            r  = r >> 1;
            if (fb) begin
                r = r ^ 32'hEDB8_8320;
            end
        end
        return r;
    endfunction

    always_comb begin
        crc_upd = crc_byte(crc_q, data);
        crc_d   = crc_q;
        if (init) begin
            crc_d = 32'hFFFF_FFFF;
        end else if (en) begin
            crc_d = crc_upd;
        end
        // Reflected register: the low byte of the inverted CRC goes out first.
        crc_inv = en ? ~crc_upd : ~crc_q;
        new_crc = {crc_inv[7:0], crc_inv[15:8], crc_inv[23:16], crc_inv[31:24]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            crc_q <= 32'hFFFF_FFFF;
        end else begin
            crc_q <= crc_d;
        end
    end
endmodule

// ----------------------------------------------------------------------------
// eth_gmii_rx top
// ----------------------------------------------------------------------------
module eth_gmii_rx #(
    parameter int MAX_FRAME_LEN = 1518,
    parameter int MIN_DATA_LEN  = 60
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        sgmii_clk_en,
    input  logic [7:0]  gmii_rxd,
    input  logic        gmii_rx_dv,
    input  logic        gmii_rx_er,
    output logic        data_fifo_wr,
    output logic [7:0]  data_fifo_data_in,
    input  logic        data_fifo_afull,
    output logic        cmd_fifo_wr,
    output logic [71:0] cmd_fifo_data_in,
    input  logic        cmd_fifo_full,
    output logic [15:0] drop_cnt
`ifdef ETH_GMII_RX_STATS_EN
    ,
    output logic [31:0] good_frame_cnt,
    output logic [31:0] crc_err_cnt
`endif
);
    localparam logic [13:0] c_len_limit = 14'(MAX_FRAME_LEN - 4);
    localparam logic [13:0] c_min_len   = 14'(MIN_DATA_LEN);

    typedef enum logic [2:0] {
        RX_IDLE = 3'd0,
        RX_PRE  = 3'd1,
        RX_DATA = 3'd2,
        RX_CHK  = 3'd3,
        RX_CMD  = 3'd4,
        RX_DROP = 3'd5
    } rx_state_t;

    rx_state_t   state_q, state_d;
    logic [31:0] pipe_q, pipe_d;          // [31:24] is the oldest byte
    logic [2:0]  pipe_cnt_q, pipe_cnt_d;  // bytes held, saturates at 4
    logic [13:0] len_q, len_d;
    logic        frame_err_q, frame_err_d;
    logic        crc_err_q, crc_err_d;
    logic        data_wr_q, data_wr_d;
    logic [7:0]  data_q, data_d;
    logic        cmd_wr_q, cmd_wr_d;
    logic [71:0] cmd_q, cmd_d;
    logic [15:0] drop_cnt_q, drop_cnt_d;

    logic        sfd_hit;
    logic        crc_init;
    logic        crc_en;
    logic [31:0] new_crc;
    logic        desc_err;

`ifdef ETH_GMII_RX_STATS_EN
    logic [31:0] good_cnt_q, good_cnt_d;
    logic [31:0] crc_cnt_q, crc_cnt_d;
`endif

    crc32_d8 u_crc (
        .clk     (clk),
        .reset   (reset),
        .init    (crc_init),
        .en      (crc_en),
        .data    (pipe_q[31:24]),
        .new_crc (new_crc)
    );

    always_comb begin
        state_d     = state_q;
        pipe_d      = pipe_q;
        pipe_cnt_d  = pipe_cnt_q;
        len_d       = len_q;
        frame_err_d = frame_err_q;
        crc_err_d   = crc_err_q;
        data_wr_d   = 1'b0;
        data_d      = data_q;
        cmd_wr_d    = 1'b0;
        cmd_d       = cmd_q;
        drop_cnt_d  = drop_cnt_q;
        sfd_hit     = 1'b0;
        crc_init    = 1'b0;
        crc_en      = 1'b0;
        desc_err    = frame_err_q || (len_q < c_min_len);
`ifdef ETH_GMII_RX_STATS_EN
        good_cnt_d  = good_cnt_q;
        crc_cnt_d   = crc_cnt_q;
`endif

        case (state_q)
            RX_IDLE: begin
                if (sgmii_clk_en && gmii_rx_dv) begin
                    if (gmii_rxd == 8'h55) begin
                        state_d = RX_PRE;
                    end else if (gmii_rxd == 8'hD5) begin
                        sfd_hit = 1'b1;
                    end else begin
                        state_d = RX_DROP;
                    end
                end
            end

            RX_PRE: begin
                if (sgmii_clk_en) begin
                    if (!gmii_rx_dv) begin
                        state_d = RX_IDLE;
                    end else if (gmii_rxd == 8'h55) begin
                        state_d = RX_PRE;
                    end else if (gmii_rxd == 8'hD5) begin
                        sfd_hit = 1'b1;
                    end else begin
                        state_d = RX_DROP;
                    end
                end
            end

            RX_DATA: begin
                if (sgmii_clk_en) begin
                    if (gmii_rx_dv) begin
                        pipe_d = {pipe_q[23:0], gmii_rxd};
                        if (pipe_cnt_q == 3'd4) begin
                            // The evicted byte can no longer be FCS: it is data.
                            if (len_q == c_len_limit) begin
                                frame_err_d = 1'b1;
                            end else begin
                                data_wr_d = 1'b1;
                                data_d    = pipe_q[31:24];
                                crc_en    = 1'b1;
                                len_d     = len_q + 14'd1;
                            end
                        end else begin
                            pipe_cnt_d = pipe_cnt_q + 3'd1;
                        end
                        if (gmii_rx_er) begin
                            frame_err_d = 1'b1;
                        end
                    end else begin
                        state_d = RX_CHK;
                    end
                end
            end

            RX_CHK: begin
                crc_err_d = (pipe_cnt_q != 3'd4) || (pipe_q != new_crc);
                state_d   = RX_CMD;
            end

            RX_CMD: begin
                if (len_q != 14'd0) begin
                    cmd_wr_d = 1'b1;
                    cmd_d    = {18'd0, desc_err, crc_err_q, 38'd0, len_q};
`ifdef ETH_GMII_RX_STATS_EN
                    if (!desc_err && !crc_err_q) begin
                        good_cnt_d = good_cnt_q + 32'd1;
                    end
                    if (crc_err_q) begin
                        crc_cnt_d = crc_cnt_q + 32'd1;
                    end
`endif
                end
                state_d = RX_IDLE;
            end

            RX_DROP: begin
                if (sgmii_clk_en && !gmii_rx_dv) begin
                    state_d = RX_IDLE;
                end
            end

            default: begin
                state_d = RX_IDLE;
            end
        endcase

        // Space for a maximum-size frame is reserved at SFD; otherwise the
        // whole frame is discarded.
        if (sfd_hit) begin
            if (data_fifo_afull || cmd_fifo_full) begin
                state_d = RX_DROP;
                if (drop_cnt_q != 16'hFFFF) begin
                    drop_cnt_d = drop_cnt_q + 16'd1;
                end
            end else begin
                state_d     = RX_DATA;
                crc_init    = 1'b1;
                pipe_d      = 32'd0;
                pipe_cnt_d  = 3'd0;
                len_d       = 14'd0;
                frame_err_d = 1'b0;
                crc_err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= RX_IDLE;
            pipe_q      <= 32'd0;
            pipe_cnt_q  <= 3'd0;
            len_q       <= 14'd0;
            frame_err_q <= 1'b0;
            crc_err_q   <= 1'b0;
            data_wr_q   <= 1'b0;
            data_q      <= 8'd0;
            cmd_wr_q    <= 1'b0;
            cmd_q       <= 72'd0;
            drop_cnt_q  <= 16'd0;
`ifdef ETH_GMII_RX_STATS_EN
            good_cnt_q  <= 32'd0;
            crc_cnt_q   <= 32'd0;
`endif
        end else begin
            state_q     <= state_d;
            pipe_q      <= pipe_d;
            pipe_cnt_q  <= pipe_cnt_d;
            len_q       <= len_d;
            frame_err_q <= frame_err_d;
            crc_err_q   <= crc_err_d;
            data_wr_q   <= data_wr_d;
            data_q      <= data_d;
            cmd_wr_q    <= cmd_wr_d;
            cmd_q       <= cmd_d;
            drop_cnt_q  <= drop_cnt_d;
`ifdef ETH_GMII_RX_STATS_EN
            good_cnt_q  <= good_cnt_d;
            crc_cnt_q   <= crc_cnt_d;
`endif
        end
    end

    assign data_fifo_wr      = data_wr_q;
    assign data_fifo_data_in = data_q;
    assign cmd_fifo_wr       = cmd_wr_q;
    assign cmd_fifo_data_in  = cmd_q;
    assign drop_cnt          = drop_cnt_q;
`ifdef ETH_GMII_RX_STATS_EN
    assign good_frame_cnt    = good_cnt_q;
    assign crc_err_cnt       = crc_cnt_q;
`endif
endmodule

`default_nettype wire

// File: tb/tb_eth_gmii_rx.sv
// ============================================================================
// Module   : tb_eth_gmii_rx
// Purpose  : Self-checking bench for eth_gmii_rx. A table of frame records
//            is applied in a loop; a reset-during-frame sequence follows.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_eth_gmii_rx;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        sgmii_clk_en = 1'b0;
    logic [7:0]  gmii_rxd = 8'd0;
    logic        gmii_rx_dv = 1'b0;
    logic        gmii_rx_er = 1'b0;
    logic        data_fifo_wr;
    logic [7:0]  data_fifo_data_in;
    logic        data_fifo_afull = 1'b0;
    logic        cmd_fifo_wr;
    logic [71:0] cmd_fifo_data_in;
    logic        cmd_fifo_full = 1'b0;
    logic [15:0] drop_cnt;
`ifdef ETH_GMII_RX_STATS_EN
    logic [31:0] good_frame_cnt;
    logic [31:0] crc_err_cnt;
`endif

    always #4 clk = ~clk;

    eth_gmii_rx #(.MAX_FRAME_LEN(1518), .MIN_DATA_LEN(60)) dut (
        .clk               (clk),
        .reset             (reset),
        .sgmii_clk_en      (sgmii_clk_en),
        .gmii_rxd          (gmii_rxd),
        .gmii_rx_dv        (gmii_rx_dv),
        .gmii_rx_er        (gmii_rx_er),
        .data_fifo_wr      (data_fifo_wr),
        .data_fifo_data_in (data_fifo_data_in),
        .data_fifo_afull   (data_fifo_afull),
        .cmd_fifo_wr       (cmd_fifo_wr),
        .cmd_fifo_data_in  (cmd_fifo_data_in),
        .cmd_fifo_full     (cmd_fifo_full),
        .drop_cnt          (drop_cnt)
`ifdef ETH_GMII_RX_STATS_EN
        ,
        .good_frame_cnt    (good_frame_cnt),
        .crc_err_cnt       (crc_err_cnt)
`endif
    );

    // fcs_mode: 0 no FCS appended, 1 correct FCS, 2 last FCS byte inverted
    // block:    0 none, 1 cmd_fifo_full at SFD, 2 data_fifo_afull at SFD
    typedef struct {
        int nbytes;
        int fcs_mode;
        int er_at;
        int block;
        int period;
        int exp_writes;
        int exp_cmd;
        int exp_len;
        int exp_b52;
        int chk_b52;
        int exp_b53;
        int exp_drop;
    } vec_t;

    vec_t        vecs[12];
    int          total = 0;
    int          bad = 0;
    int          period = 1;
    int          width_bad = 0;
    logic        prev_dwr = 1'b0;
    logic        prev_cwr = 1'b0;
    logic [7:0]  wq[$];
    logic [71:0] cq[$];
    logic [7:0]  pl[$];
    logic [7:0]  fr[$];

    always @(negedge clk) begin
        if (!reset) begin
            if (data_fifo_wr) wq.push_back(data_fifo_data_in);
            if (cmd_fifo_wr)  cq.push_back(cmd_fifo_data_in);
            if (data_fifo_wr && prev_dwr && period > 1) width_bad++;
            if (cmd_fifo_wr && prev_cwr) width_bad++;
        end
        prev_dwr = data_fifo_wr;
        prev_cwr = cmd_fifo_wr;
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] d);
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB8_8320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic slot(input logic dv, input logic er, input logic [7:0] d);
        gmii_rx_dv = dv;
        gmii_rx_er = er;
        gmii_rxd   = d;
        for (int i = 0; i < period - 1; i++) begin
            sgmii_clk_en = 1'b0;
            @(negedge clk);
        end
        sgmii_clk_en = 1'b1;
        @(negedge clk);
        sgmii_clk_en = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        logic [31:0] c;
        logic [71:0] desc;
        int          mism;
        string       tag;
        tag    = $sformatf("v%0d", idx);
        period = v.period;
        wq.delete();
        cq.delete();
        pl.delete();
        fr.delete();
        c = 32'hFFFF_FFFF;
        for (int i = 0; i < v.nbytes; i++) begin
            pl.push_back(8'(i + 7 * idx));
            fr.push_back(8'(i + 7 * idx));
            c = crc_step(c, 8'(i + 7 * idx));
        end
        c = ~c;
        if (v.fcs_mode != 0) begin
            fr.push_back(c[7:0]);
            fr.push_back(c[15:8]);
            fr.push_back(c[23:16]);
            fr.push_back((v.fcs_mode == 2) ? ~c[31:24] : c[31:24]);
        end
        cmd_fifo_full   = (v.block == 1);
        data_fifo_afull = (v.block == 2);
        repeat (7) slot(1'b1, 1'b0, 8'h55);
        slot(1'b1, 1'b0, 8'hD5);
        foreach (fr[i]) slot(1'b1, (i == v.er_at), fr[i]);
        repeat (3) slot(1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        cmd_fifo_full   = 1'b0;
        data_fifo_afull = 1'b0;

        check({tag, "_writes"}, wq.size(), v.exp_writes);
        mism = 0;
        foreach (wq[i]) if (i < pl.size() && wq[i] != pl[i]) mism++;
        check({tag, "_data_mismatches"}, mism, 0);
        check({tag, "_cmd_count"}, cq.size(), v.exp_cmd);
        desc = (cq.size() > 0) ? cq[0] : 72'd0;
        if (v.exp_cmd != 0) begin
            check({tag, "_len"}, int'(desc[13:0]), v.exp_len);
            check({tag, "_b53"}, int'(desc[53]), v.exp_b53);
            if (v.chk_b52 != 0) check({tag, "_b52"}, int'(desc[52]), v.exp_b52);
            check({tag, "_zero_bits"}, int'(desc[71:54] != 0 || desc[51:14] != 0), 0);
        end
        check({tag, "_drop_cnt"}, int'(drop_cnt), v.exp_drop);
    endtask

    initial begin
        //            nb   fcs er  blk per wr   cmd len  b52 chk b53 drop
        vecs[0]  = '{60,   1, -1, 0, 1,  60,  1, 60,   0, 1, 0, 0};
        vecs[1]  = '{60,   2, -1, 0, 1,  60,  1, 60,   1, 1, 0, 0};
        vecs[2]  = '{96,   1, 30, 0, 1,  96,  1, 96,   0, 1, 1, 0};
        vecs[3]  = '{60,   1, -1, 1, 1,  0,   0, 0,    0, 0, 0, 1};
        vecs[4]  = '{60,   1, -1, 0, 1,  60,  1, 60,   0, 1, 0, 1};
        vecs[5]  = '{20,   1, -1, 0, 1,  20,  1, 20,   0, 1, 1, 1};
        vecs[6]  = '{2,    0, -1, 0, 1,  0,   0, 0,    0, 0, 0, 1};
        vecs[7]  = '{60,   1, -1, 2, 1,  0,   0, 0,    0, 0, 0, 2};
        vecs[8]  = '{1514, 1, -1, 0, 1,  1514,1, 1514, 0, 1, 0, 2};
        vecs[9]  = '{60,   1, -1, 0, 10, 60,  1, 60,   0, 1, 0, 2};
        vecs[10] = '{1596, 1, -1, 0, 1,  1514,1, 1514, 0, 0, 1, 2};
        vecs[11] = '{60,   1, -1, 0, 1,  60,  1, 60,   0, 1, 0, 0};

        repeat (3) @(negedge clk);
        check("reset_data_wr", int'(data_fifo_wr), 0);
        check("reset_cmd_wr", int'(cmd_fifo_wr), 0);
        check("reset_data_in", int'(data_fifo_data_in), 0);
        check("reset_cmd_nonzero", int'(cmd_fifo_data_in != 72'd0), 0);
        check("reset_drop_cnt", int'(drop_cnt), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int k = 0; k < 11; k++) run_vec(vecs[k], k);
        period = 1;
        check("strobe_width_violations", width_bad, 0);

        // Reset in the middle of a frame: 30 bytes after SFD yield 26 writes,
        // then everything clears and no descriptor follows.
        wq.delete();
        cq.delete();
        repeat (7) slot(1'b1, 1'b0, 8'h55);
        slot(1'b1, 1'b0, 8'hD5);
        for (int i = 0; i < 30; i++) slot(1'b1, 1'b0, 8'(8'h10 + i));
        @(negedge clk);
        check("midframe_writes_before_reset", wq.size(), 26);
        reset = 1'b1;
        #1;
        check("midreset_data_wr", int'(data_fifo_wr), 0);
        check("midreset_cmd_wr", int'(cmd_fifo_wr), 0);
        check("midreset_data_in", int'(data_fifo_data_in), 0);
        check("midreset_cmd_nonzero", int'(cmd_fifo_data_in != 72'd0), 0);
        check("midreset_drop_cnt", int'(drop_cnt), 0);
        wq.delete();
        cq.delete();
        for (int i = 0; i < 3; i++) slot(1'b1, 1'b0, 8'(8'h30 + i));
        reset = 1'b0;
        for (int i = 0; i < 20; i++) slot(1'b1, 1'b0, 8'(8'h40 + i));
        repeat (3) slot(1'b0, 1'b0, 8'h00);
        repeat (4) @(negedge clk);
        check("post_reset_writes", wq.size(), 0);
        check("post_reset_cmds", cq.size(), 0);
        check("post_reset_drop_cnt", int'(drop_cnt), 0);

        run_vec(vecs[11], 11);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
